// File: rtl/red_pkg.sv
// rtl/red_pkg.sv - shared types, width helpers and parameter checks for the lane-sum reduction unit
package red_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } red_state_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  // Result width is sized so the full lane sum can never overflow in either mode.
  function automatic int res_w_calc(input int data_w, input int lane_w);
    return lane_w + clog2((2 * data_w) / lane_w);
  endfunction

  function automatic int beats_calc(input int data_w, input int lane_w, input int lpc);
    return ((2 * data_w) / lane_w) / lpc;
  endfunction

  function automatic bit params_ok(input int data_w, input int lane_w, input int lpc);
    int nl;
    if (data_w <= 0 || lane_w <= 0 || lpc <= 0) return 1'b0;
    if ((data_w % lane_w) != 0) return 1'b0;
    nl = (2 * data_w) / lane_w;
    if ((nl % lpc) != 0) return 1'b0;
    if ((nl & (nl - 1)) != 0) return 1'b0;
    return 1'b1;
  endfunction

endpackage

// File: rtl/red_lane_adder.sv
// rtl/red_lane_adder.sv - combinational extend-and-add of one beat's lanes
module red_lane_adder
  import red_pkg::*;
#(
  parameter int LANE_W = 4,
  parameter int LANES  = 2,
  parameter int RES_W  = 7
) (
  input  logic [LANES-1:0][LANE_W-1:0] i_lanes,
  input  logic                         i_sgn,
  output logic [RES_W-1:0]             o_sum
);

  // Zero- or sign-extend every lane to the result width and sum them.
  always_comb begin
    logic [RES_W-1:0] v_ext;
    o_sum = '0;
    v_ext = '0;
    for (int k = 0; k < LANES; k++) begin
      if (i_sgn) begin
        v_ext = {{(RES_W - LANE_W){i_lanes[k][LANE_W-1]}}, i_lanes[k]};
      end else begin
        v_ext = {{(RES_W - LANE_W){1'b0}}, i_lanes[k]};
      end
      o_sum = o_sum + v_ext;
    end
  end

endmodule

// File: rtl/red_seq_unit.sv
// rtl/red_seq_unit.sv - multi-cycle lane-sum reduction unit with valid/ready handshakes
module red_seq_unit
  import red_pkg::*;
#(
  parameter int DATA_W        = 16,
  parameter int LANE_W        = 4,
  parameter int LANES_PER_CYC = 2
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  input  logic [DATA_W-1:0]                    a,
  input  logic [DATA_W-1:0]                    b,
  input  logic                                 sgn,
  input  logic                                 flush,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic [res_w_calc(DATA_W, LANE_W)-1:0] result,
  output logic                                 busy
);

  localparam int NLANES = (2 * DATA_W) / LANE_W;
  localparam int RES_W  = res_w_calc(DATA_W, LANE_W);
  localparam int BEATS  = beats_calc(DATA_W, LANE_W, LANES_PER_CYC);
  localparam int IDX_W  = clog2(NLANES);

  if (!params_ok(DATA_W, LANE_W, LANES_PER_CYC)) begin : g_param_check
    $error("red_seq_unit: illegal DATA_W/LANE_W/LANES_PER_CYC combination");
  end

  red_state_t                          r_state;
  red_state_t                          w_state_next;
  logic [DATA_W-1:0]                   r_a;
  logic [DATA_W-1:0]                   r_b;
  logic                                r_sgn;
  logic [RES_W-1:0]                    r_acc;
  logic [IDX_W-1:0]                    r_idx;
  logic [NLANES-1:0][LANE_W-1:0]       w_lane_arr;
  logic [LANES_PER_CYC-1:0][LANE_W-1:0] w_lanes;
  logic [RES_W-1:0]                    w_part;
  logic                                w_last_beat;

  // Lane 0 is a's low lane; b's lanes follow a's.
  assign w_lane_arr  = {r_b, r_a};
  assign w_last_beat = (r_idx == IDX_W'((BEATS - 1) * LANES_PER_CYC));
  assign result      = r_acc;

  // Select this beat's lanes; NLANES is a power of two so idx indexes exactly.
  always_comb begin
    w_lanes = '0;
    for (int k = 0; k < LANES_PER_CYC; k++) begin
      w_lanes[k] = w_lane_arr[r_idx + IDX_W'(k)];
    end
  end

  red_lane_adder #(
    .LANE_W (LANE_W),
    .LANES  (LANES_PER_CYC),
    .RES_W  (RES_W)
  ) u_lane_adder (
    .i_lanes (w_lanes),
    .i_sgn   (r_sgn),
    .o_sum   (w_part)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state and handshake decodes; flush overrides both handshakes.
  always_comb begin
    w_state_next = r_state;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    busy         = 1'b1;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) w_state_next = BUSY;
      end
      BUSY: begin
        if (w_last_beat) w_state_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
    if (flush) w_state_next = IDLE;
  end

  // Operand capture and beat-by-beat accumulation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a   <= '0;
      r_b   <= '0;
      r_sgn <= 1'b0;
      r_acc <= '0;
      r_idx <= '0;
    end else if (flush) begin
      r_acc <= '0;
      r_idx <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_a   <= a;
            r_b   <= b;
            r_sgn <= sgn;
            r_acc <= '0;
            r_idx <= '0;
          end
        end
        BUSY: begin
          r_acc <= r_acc + w_part;
          r_idx <= r_idx + IDX_W'(LANES_PER_CYC);
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_red_seq_unit.sv
// tb/tb_red_seq_unit.sv - randomized self-checking bench for red_seq_unit across several configurations
module tb_red_seq_unit;

  localparam int NCFG = 5;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [15:0] a;
  logic [15:0] b;
  logic        sgn;
  logic        flush;
  logic        out_ready;

  logic [NCFG-1:0] ir;
  logic [NCFG-1:0] ov;
  logic [NCFG-1:0] bz;
  logic [6:0]      res0, res1, res2, res3;
  logic [9:0]      res4;

  int cfg_lw  [NCFG] = '{4, 4, 4, 4, 8};
  int cfg_lpc [NCFG] = '{2, 1, 4, 8, 2};

  int n_checks = 0;
  int n_errors = 0;
  int got_lat [NCFG];
  int got_res [NCFG];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  red_seq_unit #(.DATA_W(16), .LANE_W(4), .LANES_PER_CYC(2)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[0]), .a(a), .b(b), .sgn(sgn),
    .flush(flush), .out_valid(ov[0]), .out_ready(out_ready), .result(res0), .busy(bz[0]));
  red_seq_unit #(.DATA_W(16), .LANE_W(4), .LANES_PER_CYC(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[1]), .a(a), .b(b), .sgn(sgn),
    .flush(flush), .out_valid(ov[1]), .out_ready(out_ready), .result(res1), .busy(bz[1]));
  red_seq_unit #(.DATA_W(16), .LANE_W(4), .LANES_PER_CYC(4)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[2]), .a(a), .b(b), .sgn(sgn),
    .flush(flush), .out_valid(ov[2]), .out_ready(out_ready), .result(res2), .busy(bz[2]));
  red_seq_unit #(.DATA_W(16), .LANE_W(4), .LANES_PER_CYC(8)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[3]), .a(a), .b(b), .sgn(sgn),
    .flush(flush), .out_valid(ov[3]), .out_ready(out_ready), .result(res3), .busy(bz[3]));
  red_seq_unit #(.DATA_W(16), .LANE_W(8), .LANES_PER_CYC(2)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[4]), .a(a), .b(b), .sgn(sgn),
    .flush(flush), .out_valid(ov[4]), .out_ready(out_ready), .result(res4), .busy(bz[4]));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int log2i(input int v);
    int r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  function automatic int beats_of(input int i);
    return (32 / cfg_lw[i]) / cfg_lpc[i];
  endfunction

  // Reference: plain integer sum of every lane, wrapped to the result width.
  function automatic int model(input logic [15:0] ma, input logic [15:0] mb, input logic ms, input int lw);
    logic [31:0] all;
    int sum;
    int nl;
    int rw;
    all = {mb, ma};
    sum = 0;
    nl  = 32 / lw;
    rw  = lw + log2i(nl);
    for (int i = 0; i < nl; i++) begin
      int v;
      v = int'((all >> (i * lw)) & ((32'd1 << lw) - 1));
      if (ms && v >= (1 << (lw - 1))) v = v - (1 << lw);
      sum = sum + v;
    end
    return sum & ((1 << rw) - 1);
  endfunction

  function automatic int res_of(input int i);
    case (i)
      0: return int'(res0);
      1: return int'(res1);
      2: return int'(res2);
      3: return int'(res3);
      default: return int'(res4);
    endcase
  endfunction

  task automatic wait_all_idle();
    int w = 0;
    while (ir !== {NCFG{1'b1}} && w < 50) begin
      @(negedge clk);
      w++;
    end
    check("idle_wait", ir, {NCFG{1'b1}});
  endtask

  // One operation on every configuration at once; operands are scrambled after capture.
  task automatic run_op(input logic [15:0] ta, input logic [15:0] tb_v, input logic ts);
    wait_all_idle();
    @(negedge clk);
    a = ta; b = tb_v; sgn = ts; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    a = 16'($urandom); b = 16'($urandom); sgn = 1'($urandom);
    for (int i = 0; i < NCFG; i++) begin
      got_lat[i] = -1;
      got_res[i] = 0;
    end
    for (int c = 0; c < 20; c++) begin
      for (int i = 0; i < NCFG; i++) begin
        if (ov[i] && got_lat[i] < 0) begin
          got_lat[i] = c;
          got_res[i] = res_of(i);
        end
      end
      @(negedge clk);
    end
    for (int i = 0; i < NCFG; i++) begin
      check($sformatf("res_cfg%0d a=%h b=%h s=%0d", i, ta, tb_v, ts), got_res[i], model(ta, tb_v, ts, cfg_lw[i]));
      check($sformatf("lat_cfg%0d", i), got_lat[i], beats_of(i));
    end
  endtask

  initial begin
    int w;
    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; sgn = 1'b0; flush = 1'b0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_in_ready", ir, {NCFG{1'b1}});
    check("rst_out_valid", ov, '0);
    check("rst_busy", bz, '0);
    check("rst_result", res0, 0);
    rst_n = 1'b1;

    run_op(16'h1234, 16'h5678, 1'b0);
    check("d_1234_5678", got_res[0], 32'h24);
    check("d_latency", got_lat[0], 4);
    run_op(16'hFFFF, 16'hFFFF, 1'b0);
    check("d_ffff", got_res[0], 32'h78);
    run_op(16'h7777, 16'h7777, 1'b1);
    check("d_7777_s", got_res[0], 32'h38);
    run_op(16'h8888, 16'h8888, 1'b1);
    check("d_8888_s", got_res[0], 32'h40);

    // Backpressure: result and status held while the consumer stalls.
    wait_all_idle();
    @(negedge clk);
    a = 16'hBEEF; b = 16'h1357; sgn = 1'b1; in_valid = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0; a = 16'h0; b = 16'h0;
    w = 0;
    while (!ov[0] && w < 20) begin
      @(negedge clk);
      w++;
    end
    check("bp_reach_done", ov[0], 1'b1);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("bp_out_valid", ov[0], 1'b1);
      check("bp_result", res0, model(16'hBEEF, 16'h1357, 1'b1, 4));
      check("bp_busy", bz[0], 1'b1);
      check("bp_in_ready", ir[0], 1'b0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_release_in_ready", ir[0], 1'b1);
    check("bp_release_out_valid", ov[0], 1'b0);

    // Flush on the second BUSY cycle: no result, then a clean follow-up operation.
    wait_all_idle();
    @(negedge clk);
    a = 16'hFFFF; b = 16'hFFFF; sgn = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    check("fl_busy1_ov", ov[0], 1'b0);
    @(negedge clk);
    check("fl_busy2_ov", ov[0], 1'b0);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("fl_in_ready", ir[0], 1'b1);
    check("fl_busy", bz[0], 1'b0);
    for (int c = 0; c < 3; c++) begin
      check("fl_no_ov", ov[0], 1'b0);
      @(negedge clk);
    end
    run_op(16'h0001, 16'h0000, 1'b0);
    check("fl_follow", got_res[0], 32'h01);

    // Asynchronous reset between clock edges in the middle of BUSY.
    wait_all_idle();
    @(negedge clk);
    a = 16'hFFFF; b = 16'hFFFF; sgn = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("ar_in_ready", ir[0], 1'b1);
    check("ar_out_valid", ov[0], 1'b0);
    check("ar_busy", bz[0], 1'b0);
    check("ar_result", res0, 0);
    #1 rst_n = 1'b1;
    run_op(16'h00F3, 16'h2000, 1'b0);
    check("ar_follow", got_res[0], 32'h14);

    // Random sweep over both modes on every configuration.
    for (int n = 0; n < 40; n++) begin
      run_op(16'($urandom), 16'($urandom), 1'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
